// File: rtl/array_refresh_mb.sv
// array_refresh_mb
// Multi-bank, multi-row refresh engine. One start request refreshes a
// programmable number of rows, either with every bank at once or one bank
// after another. Each refresh is an ACT window (tRAS cycles) followed by a
// PRE window (tRP cycles). A row pointer persists across requests and is
// only cleared by reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   array_rf_start    request pulse, only honoured in IDLE
//   array_rf_mode     0 = all-bank, 1 = per-bank sequential (latched at start)
//   array_rf_rows     rows per request, 0 behaves as 1 (latched at start)
//   array_tRAS/tRP    ACT/PRE window lengths, 0 behaves as 1 (latched at start)
//   array_rf_busy     high from the cycle after acceptance through DONE
//   array_rf_done     one-cycle completion pulse
//   array_cs_n        per-bank active-low chip select
//   array_raddr       row currently being refreshed (the row pointer)
//   array_rf_bank     bank in ACT/PRE for per-bank mode, 0 otherwise
module array_refresh_mb #(
    parameter int ARRAY_ROW_ADDR_WIDTH = 16,
    parameter int BANK_NUM             = 4,
    parameter int BANK_W               = 2,
    parameter int TIMER_WIDTH          = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            array_rf_start,
    input  logic                            array_rf_mode,
    input  logic [7:0]                      array_rf_rows,
    output logic                            array_rf_busy,
    output logic                            array_rf_done,
    input  logic [TIMER_WIDTH-1:0]          array_tRAS,
    input  logic [TIMER_WIDTH-1:0]          array_tRP,
    output logic [BANK_NUM-1:0]             array_cs_n,
    output logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_raddr,
    output logic [BANK_W-1:0]               array_rf_bank
);

    typedef enum logic [1:0] {IDLE, ACT, PRE, DONE} state_t;

    localparam logic [BANK_W-1:0]               LAST_BANK = BANK_W'(BANK_NUM - 1);
    localparam logic [BANK_W-1:0]               BANK_ONE  = BANK_W'(1);
    localparam logic [ARRAY_ROW_ADDR_WIDTH-1:0] ROW_ONE   = ARRAY_ROW_ADDR_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0]          TIMER_ONE = TIMER_WIDTH'(1);

    state_t                        state, state_nxt;
    logic [TIMER_WIDTH-1:0]        timer, timer_nxt;
    logic [TIMER_WIDTH-1:0]        tras_m1, tras_m1_nxt;
    logic [TIMER_WIDTH-1:0]        trp_m1, trp_m1_nxt;
    logic [7:0]                    rows_left, rows_left_nxt;
    logic                          mode, mode_nxt;
    logic [ARRAY_ROW_ADDR_WIDTH-1:0] row_ptr, row_ptr_nxt;
    logic [BANK_W-1:0]             bank, bank_nxt;
    logic [BANK_NUM-1:0]           cs_n, cs_n_nxt;
    logic                          busy, busy_nxt;
    logic                          done, done_nxt;

    // Window lengths are stored as "length minus one" so the timer can
    // count down to zero; a programmed 0 collapses to a single cycle.
    function automatic logic [TIMER_WIDTH-1:0] len_m1(input logic [TIMER_WIDTH-1:0] len);
        return (len == '0) ? '0 : len - TIMER_ONE;
    endfunction

    // Chip-select pattern for an ACT window: every bank low in all-bank
    // mode, only the selected bank low in per-bank mode.
    function automatic logic [BANK_NUM-1:0] act_mask(input logic per_bank,
                                                     input logic [BANK_W-1:0] b);
        logic [BANK_NUM-1:0] m;
        m = '0;
        if (per_bank) begin
            m    = '1;
            m[b] = 1'b0;
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            tras_m1   <= '0;
            trp_m1    <= '0;
            rows_left <= '0;
            mode      <= 1'b0;
            row_ptr   <= '0;
            bank      <= '0;
            cs_n      <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            tras_m1   <= tras_m1_nxt;
            trp_m1    <= trp_m1_nxt;
            rows_left <= rows_left_nxt;
            mode      <= mode_nxt;
            row_ptr   <= row_ptr_nxt;
            bank      <= bank_nxt;
            cs_n      <= cs_n_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and next-output logic. Every output is computed one cycle
    // ahead here so that the outputs themselves come straight from flops.
    // The row pointer only moves when a whole row (all banks in per-bank
    // mode) has finished its PRE window, so raddr is stable through ACT.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        tras_m1_nxt   = tras_m1;
        trp_m1_nxt    = trp_m1;
        rows_left_nxt = rows_left;
        mode_nxt      = mode;
        row_ptr_nxt   = row_ptr;
        bank_nxt      = bank;
        cs_n_nxt      = cs_n;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (array_rf_start) begin
                    state_nxt     = ACT;
                    mode_nxt      = array_rf_mode;
                    rows_left_nxt = (array_rf_rows == 8'd0) ? 8'd1 : array_rf_rows;
                    tras_m1_nxt   = len_m1(array_tRAS);
                    trp_m1_nxt    = len_m1(array_tRP);
                    timer_nxt     = len_m1(array_tRAS);
                    bank_nxt      = '0;
                    cs_n_nxt      = act_mask(array_rf_mode, '0);
                    busy_nxt      = 1'b1;
                end
            end
            ACT: begin
                if (timer == '0) begin
                    state_nxt = PRE;
                    timer_nxt = trp_m1;
                    cs_n_nxt  = '1;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            PRE: begin
                if (timer != '0) begin
                    timer_nxt = timer - TIMER_ONE;
                end else if (mode && (bank != LAST_BANK)) begin
                    state_nxt = ACT;
                    timer_nxt = tras_m1;
                    bank_nxt  = bank + BANK_ONE;
                    cs_n_nxt  = act_mask(1'b1, bank + BANK_ONE);
                end else begin
                    row_ptr_nxt   = row_ptr + ROW_ONE;
                    rows_left_nxt = rows_left - 8'd1;
                    bank_nxt      = '0;
                    if (rows_left != 8'd1) begin
                        state_nxt = ACT;
                        timer_nxt = tras_m1;
                        cs_n_nxt  = act_mask(mode, '0);
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                cs_n_nxt  = '1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign array_rf_busy = busy;
    assign array_rf_done = done;
    assign array_cs_n    = cs_n;
    assign array_raddr   = row_ptr;
    assign array_rf_bank = bank;

endmodule

// File: tb/tb_array_refresh_mb.sv
// tb_array_refresh_mb
// Bench for array_refresh_mb. Two instances share all inputs: the default
// 16-bit row pointer build and a 4-bit row pointer build (to see the wrap).
// A behavioural model expands every accepted request into the expected
// per-cycle output sequence and a compare process checks it each cycle;
// directed requests additionally pin cycle counts and addresses to
// hand-computed values.
module tb_array_refresh_mb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        array_rf_start = 1'b0;
    logic        array_rf_mode = 1'b0;
    logic [7:0]  array_rf_rows = 8'd0;
    logic [7:0]  array_tRAS = 8'd0;
    logic [7:0]  array_tRP = 8'd0;
    logic        array_rf_busy, array_rf_done;
    logic [3:0]  array_cs_n;
    logic [15:0] array_raddr;
    logic [1:0]  array_rf_bank;
    logic        busy2, done2;
    logic [3:0]  cs_n2;
    logic [3:0]  raddr2;
    logic [1:0]  bank2;

    int errors = 0;
    int checks = 0;
    bit checks_on = 1'b0;

    always #5 clk = ~clk;

    array_refresh_mb dut (
        .clk(clk), .rst_n(rst_n), .array_rf_start(array_rf_start),
        .array_rf_mode(array_rf_mode), .array_rf_rows(array_rf_rows),
        .array_rf_busy(array_rf_busy), .array_rf_done(array_rf_done),
        .array_tRAS(array_tRAS), .array_tRP(array_tRP), .array_cs_n(array_cs_n),
        .array_raddr(array_raddr), .array_rf_bank(array_rf_bank)
    );

    array_refresh_mb #(.ARRAY_ROW_ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .array_rf_start(array_rf_start),
        .array_rf_mode(array_rf_mode), .array_rf_rows(array_rf_rows),
        .array_rf_busy(busy2), .array_rf_done(done2),
        .array_tRAS(array_tRAS), .array_tRP(array_tRP), .array_cs_n(cs_n2),
        .array_raddr(raddr2), .array_rf_bank(bank2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  cs_n;
        logic [15:0] raddr;
        logic [1:0]  bank;
        logic        bank_valid;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] model_ptr;

    function automatic exp_t idle_exp(input logic [15:0] ptr);
        exp_t e;
        e.cs_n = 4'hF; e.raddr = ptr; e.bank = 2'd0; e.bank_valid = 1'b0;
        e.busy = 1'b0; e.done = 1'b0;
        return e;
    endfunction

    // Expand one accepted request into its full cycle-by-cycle schedule.
    task automatic build_request(input logic mode, input logic [7:0] rows,
                                 input logic [7:0] tras, input logic [7:0] trp);
        int r_cnt, b_cnt, t_act, t_pre;
        exp_t e;
        r_cnt = (rows == 0) ? 1 : int'(rows);
        b_cnt = mode ? 4 : 1;
        t_act = (tras == 0) ? 1 : int'(tras);
        t_pre = (trp == 0) ? 1 : int'(trp);
        for (int r = 0; r < r_cnt; r++) begin
            for (int b = 0; b < b_cnt; b++) begin
                e.raddr = model_ptr + 16'(r);
                e.bank = mode ? 2'(b) : 2'd0;
                e.bank_valid = 1'b1;
                e.busy = 1'b1;
                e.done = 1'b0;
                for (int t = 0; t < t_act; t++) begin
                    e.cs_n = mode ? ~(4'b0001 << b) : 4'b0000;
                    exp_q.push_back(e);
                end
                for (int t = 0; t < t_pre; t++) begin
                    e.cs_n = 4'hF;
                    exp_q.push_back(e);
                end
            end
        end
        model_ptr = model_ptr + 16'(r_cnt);
        e = idle_exp(model_ptr);
        e.busy = 1'b1;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_ptr = 16'd0;
            cur = idle_exp(16'd0);
        end else begin
            if (!cur.busy && array_rf_start)
                build_request(array_rf_mode, array_rf_rows, array_tRAS, array_tRP);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = idle_exp(model_ptr);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checks_on && rst_n) begin
            checkOutput("busy", array_rf_busy, cur.busy);
            checkOutput("done", array_rf_done, cur.done);
            checkOutput("cs_n", array_cs_n, cur.cs_n);
            checkOutput("raddr", array_raddr, cur.raddr);
            checkOutput("cs_n_w4", cs_n2, cur.cs_n);
            checkOutput("raddr_w4", raddr2, cur.raddr[3:0]);
            if (cur.bank_valid) checkOutput("rf_bank", array_rf_bank, cur.bank);
        end
    end

    // ---------------- stimulus ----------------
    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic scramble_config();
        array_rf_mode = 1'($urandom);
        array_rf_rows = 8'($urandom);
        array_tRAS = 8'($urandom);
        array_tRP = 8'($urandom);
    endtask

    // Issue one request and follow it to its done pulse. Cycle 1 is the
    // first cycle cs_n may be low; cycles is the index of the done cycle.
    task automatic applyStimulus(input logic mode, input logic [7:0] rows,
                                 input logic [7:0] tras, input logic [7:0] trp,
                                 input bit restart, output int cycles,
                                 output logic [3:0] first_cs, output logic [15:0] first_addr,
                                 output logic [15:0] after_addr, output logic [3:0] after_addr2);
        @(negedge clk);
        array_rf_mode = mode;
        array_rf_rows = rows;
        array_tRAS = tras;
        array_tRP = trp;
        array_rf_start = 1'b1;
        @(negedge clk);
        array_rf_start = 1'b0;
        first_cs = array_cs_n;
        first_addr = array_raddr;
        cycles = 1;
        while (!array_rf_done && cycles < 4000) begin
            array_rf_start = restart && (cycles == 2);
            scramble_config();
            @(negedge clk);
            cycles++;
        end
        if (!array_rf_done) checkOutput("done_timeout", array_rf_done, 1);
        array_rf_start = restart;
        @(negedge clk);
        array_rf_start = 1'b0;
        checkOutput("busy_after_done", array_rf_busy, 0);
        after_addr = array_raddr;
        after_addr2 = raddr2;
    endtask

    initial begin
        int cyc, extra;
        logic [3:0]  fcs, aa2;
        logic [15:0] fa, aa;

        #2 rst_n = 1'b0;
        #11 rst_n = 1'b1;
        checks_on = 1'b1;
        @(negedge clk);
        checkOutput("reset_cs_n", array_cs_n, 4'hF);
        checkOutput("reset_raddr", array_raddr, 16'd0);
        checkOutput("reset_busy", array_rf_busy, 0);
        checkOutput("reset_done", array_rf_done, 0);

        // T1 all-bank single row
        applyStimulus(1'b0, 8'd1, 8'h10, 8'h06, 1'b0, cyc, fcs, fa, aa, aa2);
        checkOutput("t1_cycles", cyc, 23);
        checkOutput("t1_first_cs", fcs, 4'b0000);
        checkOutput("t1_first_addr", fa, 16'd0);
        checkOutput("t1_after_addr", aa, 16'd1);

        // T2 per-bank two rows, continuing from row 1
        applyStimulus(1'b1, 8'd2, 8'd4, 8'd2, 1'b0, cyc, fcs, fa, aa, aa2);
        checkOutput("t2_cycles", cyc, 49);
        checkOutput("t2_first_cs", fcs, 4'b1110);
        checkOutput("t2_first_addr", fa, 16'd1);
        checkOutput("t2_after_addr", aa, 16'd3);

        // T3 17 rows: 4-bit pointer wraps back through 0
        reset_dut();
        applyStimulus(1'b0, 8'd17, 8'd1, 8'd1, 1'b0, cyc, fcs, fa, aa, aa2);
        checkOutput("t3_cycles", cyc, 35);
        checkOutput("t3_after_addr_w4", aa2, 4'd1);
        checkOutput("t3_after_addr", aa, 16'd17);

        // T4 zero config collapses to 1/1/1
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, cyc, fcs, fa, aa, aa2);
        checkOutput("t4_cycles", cyc, 3);
        checkOutput("t4_after_addr", aa, 16'd18);

        // T5 start re-asserted during ACT and on the DONE cycle
        applyStimulus(1'b0, 8'd1, 8'd8, 8'd2, 1'b1, cyc, fcs, fa, aa, aa2);
        checkOutput("t5_cycles", cyc, 11);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (array_rf_done || array_rf_busy) extra++;
        end
        checkOutput("t5_no_second_request", extra, 0);

        // T6 reset during the ACT window of row 5
        reset_dut();
        @(negedge clk);
        array_rf_mode = 1'b0; array_rf_rows = 8'd10; array_tRAS = 8'd3; array_tRP = 8'd1;
        array_rf_start = 1'b1;
        @(negedge clk);
        array_rf_start = 1'b0;
        cyc = 0;
        while (!(array_raddr == 16'd5 && array_cs_n == 4'h0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6_reached_row5", array_raddr, 16'd5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_cs_n", array_cs_n, 4'hF);
        checkOutput("t6_raddr", array_raddr, 16'd0);
        checkOutput("t6_busy", array_rf_busy, 0);
        checkOutput("t6_done", array_rf_done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 8'd1, 8'd2, 8'd1, 1'b0, cyc, fcs, fa, aa, aa2);
        checkOutput("t6_next_row", fa, 16'd0);
        checkOutput("t6_after_addr", aa, 16'd1);

        // Randomized requests, idle gaps and stray starts, checked by the model
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 5)),
                          8'($urandom_range(0, 3)), 1'($urandom), cyc, fcs, fa, aa, aa2);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
